// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: one outstanding word request, single-entry output slot,
// stall back-pressure, redirect and HALT handling. Optional counters: FETCH_PERF_CNT_EN.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned PC_STEP     = 4,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic        clk,
  input  logic        Reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] InstructionCode,
  output logic [31:0] pc_out,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] mem_wait_count,
  output logic [31:0] stall_count
`endif
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        valid_reg, valid_next;
  logic [31:0] code_reg, code_next;
  logic [31:0] pc_out_reg, pc_out_next;

  logic transfer;
  logic take;
  logic is_halt_word;

  assign transfer     = mem_req && mem_ready;
  assign take         = valid_reg && !stall;
  assign is_halt_word = (mem_rdata[31:26] == HALT_OPCODE);

  // State register
  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; redirect overrides everything except reset
  always_comb begin
    state_next = state_reg;
    if (redirect_en) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:  state_next = ST_FETCH;
        ST_FETCH: if (transfer && is_halt_word) state_next = ST_HALT;
        ST_HALT:  state_next = ST_HALT;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    mem_req = 1'b0;
    halted  = 1'b0;
    case (state_reg)
      ST_FETCH: mem_req = !valid_reg || !stall;
      ST_HALT:  halted  = 1'b1;
      default:  ;
    endcase
  end

  // Slot and PC update; a redirect discards any same-cycle transfer
  always_comb begin
    pc_next     = pc_reg;
    valid_next  = valid_reg;
    code_next   = code_reg;
    pc_out_next = pc_out_reg;
    if (redirect_en) begin
      pc_next    = redirect_pc & 32'hFFFF_FFFC;
      valid_next = 1'b0;
    end else if (transfer) begin
      code_next   = mem_rdata;
      pc_out_next = pc_reg;
      valid_next  = 1'b1;
      pc_next     = pc_reg + STEP;
    end else if (take) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      pc_reg     <= RESET_PC;
      valid_reg  <= 1'b0;
      code_reg   <= 32'h0;
      pc_out_reg <= 32'h0;
    end else begin
      pc_reg     <= pc_next;
      valid_reg  <= valid_next;
      code_reg   <= code_next;
      pc_out_reg <= pc_out_next;
    end
  end

  assign mem_addr        = pc_reg;
  assign instr_valid     = valid_reg;
  assign InstructionCode = code_reg;
  assign pc_out          = pc_out_reg;

`ifdef FETCH_PERF_CNT_EN
  // Counter order: fetches, memory wait cycles, stalled-slot cycles
  logic [2:0]  cnt_inc;
  logic [31:0] cnt_reg [3];

  assign cnt_inc[0] = transfer;
  assign cnt_inc[1] = mem_req && !mem_ready;
  assign cnt_inc[2] = valid_reg && stall;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (!Reset) begin
          cnt_reg[gi] <= 32'h0;
        end else if (cnt_inc[gi]) begin
          cnt_reg[gi] <= cnt_reg[gi] + 32'h1;
        end
      end
    end
  endgenerate

  assign fetch_count    = cnt_reg[0];
  assign mem_wait_count = cnt_reg[1];
  assign stall_count    = cnt_reg[2];
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a memory model answers requests, fetched
// words are queued at transfer and compared while they sit in the output slot.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic [31:0] InstructionCode;
  logic [31:0] pc_out;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, mem_wait_count, stall_count;
  logic [31:0] m_fetch, m_wait, m_stall;
`endif

  fetch_sequencer dut (
    .clk             (clk),
    .Reset           (Reset),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ready       (mem_ready),
    .mem_rdata       (mem_rdata),
    .stall           (stall),
    .redirect_en     (redirect_en),
    .redirect_pc     (redirect_pc),
    .instr_valid     (instr_valid),
    .InstructionCode (InstructionCode),
    .pc_out          (pc_out),
    .halted          (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count     (fetch_count),
    .mem_wait_count  (mem_wait_count),
    .stall_count     (stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } slot_t;

  localparam int S_IDLE  = 0;
  localparam int S_FETCH = 1;
  localparam int S_HALT  = 2;

  slot_t       sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_state;
  logic [31:0] exp_pc;
  logic        exp_valid;
  logic [31:0] halt_addr = 32'h0000_0010;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == halt_addr) return 32'hFC00_0000;
    return {6'b000101, a[25:0] ^ 26'h2AB_CDEF};
  endfunction

  task automatic do_reset();
    Reset = 1'b0; mem_ready = 1'b1; stall = 1'b0; redirect_en = 1'b0;
    mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    Reset = 1'b1; mem_ready = 1'b0;
    #1;
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_code", InstructionCode, 32'h0);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_mem_req", 32'(mem_req), 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_fetch_cnt", fetch_count, 32'h0);
    check("rst_wait_cnt", mem_wait_count, 32'h0);
    check("rst_stall_cnt", stall_count, 32'h0);
    m_fetch = 0; m_wait = 0; m_stall = 0;
`endif
    exp_state = S_IDLE; exp_pc = 32'h0; exp_valid = 1'b0;
    sb_q.delete();
    $display("[TB] reset");
  endtask

  // One clock cycle: drive inputs, check outputs, advance the reference.
  task automatic step(input logic rdy, input logic stl, input logic rd, input logic [31:0] rpc);
    logic  exp_req, tr, tk;
    slot_t e;
    mem_ready = rdy; stall = stl; redirect_en = rd; redirect_pc = rpc;
    mem_rdata = rdy ? mem_word(mem_addr) : 32'hFFFF_FFFF;
    #1;
    exp_req = (exp_state == S_FETCH) && (!exp_valid || !stl);
    check("mem_req", 32'(mem_req), 32'(exp_req));
    if (exp_req) check("mem_addr", mem_addr, exp_pc);
    check("instr_valid", 32'(instr_valid), 32'(exp_valid));
    check("halted", 32'(halted), 32'(exp_state == S_HALT));
    if (exp_valid && sb_q.size() > 0) begin
      check("instr", InstructionCode, sb_q[0].word);
      check("pc_out", pc_out, sb_q[0].pc);
    end
`ifdef FETCH_PERF_CNT_EN
    check("fetch_cnt", fetch_count, m_fetch);
    check("wait_cnt", mem_wait_count, m_wait);
    check("stall_cnt", stall_count, m_stall);
    if (exp_req && rdy) m_fetch++;
    if (exp_req && !rdy) m_wait++;
    if (exp_valid && stl) m_stall++;
`endif
    tr = exp_req && rdy;
    tk = exp_valid && !stl;
    if (rd) begin
      if (exp_valid && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (tk) $display("[TB] take pc=%h instr=%h (redirect)", e.pc, e.word);
      end
      exp_valid = 1'b0;
      exp_pc    = rpc & 32'hFFFF_FFFC;
      exp_state = S_IDLE;
      $display("[TB] redirect to %h", exp_pc);
    end else begin
      if (tk && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        $display("[TB] take pc=%h instr=%h", e.pc, e.word);
      end
      if (exp_state == S_IDLE) exp_state = S_FETCH;
      else if (tr && mem_word(exp_pc) == 32'hFC00_0000) exp_state = S_HALT;
      if (tr) begin
        e.pc = exp_pc; e.word = mem_word(exp_pc);
        sb_q.push_back(e);
        exp_pc    = exp_pc + 32'd4;
        exp_valid = 1'b1;
      end else if (tk) begin
        exp_valid = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    halt_addr = 32'hFFFF_FFFF;
    @(negedge clk);
    do_reset();
    // Straight-line fetch
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    // Memory wait of three cycles
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(1, 0, 0, 0);
    // Decode stall for four cycles with a full slot
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    // Redirect during a wait, with a same-cycle ready that must be dropped
    step(0, 0, 0, 0);
    step(1, 0, 1, 32'h0000_0103);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    // HALT word at 0x10
    halt_addr = 32'h0000_0010;
    step(1, 0, 1, 32'h0000_0010);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    check("halt_latched", 32'(halted), 32'h1);
    step(1, 0, 1, 32'h0000_0040);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    check("halt_cleared", 32'(halted), 32'h0);
    // PC wrap and reset mid-wait
    step(1, 0, 1, 32'hFFFF_FFFC);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    // Random traffic with occasional redirects into a region holding a HALT word
    halt_addr = 32'h0000_0050;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 24) == 0, 32'($urandom_range(0, 127)));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
